// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants and decode helper.
// Shared by the sync generator and the colour/font stages so border positions track the timing.
package vga_timing_pkg;

  localparam int COORD_W = 10;

  localparam int DEF_H_BP   = 48;
  localparam int DEF_H_ACT  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_V_BP   = 33;
  localparam int DEF_V_ACT  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;

  // *_END and *_SYNC_START are the first count past the preceding region
  localparam int H_TOTAL      = DEF_H_BP + DEF_H_ACT + DEF_H_FP + DEF_H_SYNC;
  localparam int H_ACT_START  = DEF_H_BP;
  localparam int H_ACT_END    = DEF_H_BP + DEF_H_ACT;
  localparam int H_SYNC_START = DEF_H_BP + DEF_H_ACT + DEF_H_FP;
  localparam int V_TOTAL      = DEF_V_BP + DEF_V_ACT + DEF_V_FP + DEF_V_SYNC;
  localparam int V_ACT_START  = DEF_V_BP;
  localparam int V_ACT_END    = DEF_V_BP + DEF_V_ACT;
  localparam int V_SYNC_START = DEF_V_BP + DEF_V_ACT + DEF_V_FP;

  function automatic logic in_span(input logic [COORD_W-1:0] val,
                                   input logic [COORD_W-1:0] lo,
                                   input logic [COORD_W-1:0] hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Timing bundle from vga_sync_gen to the colour/border stage.
// frame_start exists only when VGA_FRAME_PULSE_EN is defined.
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic               pix_tick;
  logic [COORD_W-1:0] Qh;
  logic [COORD_W-1:0] Qv;
  logic               H_ON;
  logic               V_ON;
  logic               hsync;
  logic               vsync;
`ifdef VGA_FRAME_PULSE_EN
  logic               frame_start;

  modport master (output pix_tick, Qh, Qv, H_ON, V_ON, hsync, vsync, frame_start);
  modport slave  (input  pix_tick, Qh, Qv, H_ON, V_ON, hsync, vsync, frame_start);
`else
  modport master (output pix_tick, Qh, Qv, H_ON, V_ON, hsync, vsync);
  modport slave  (input  pix_tick, Qh, Qv, H_ON, V_ON, hsync, vsync);
`endif

endinterface

// File: rtl/pix_clk_en.sv
// Clock-enable divider: registered one-clk tick every CLK_DIV clocks.
// With CLK_DIV = 1 the tick is held high from the first clock after reset.
module pix_clk_en #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic resetM,
  output logic tick
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic             wrap;

  assign wrap = (div == DIV_LAST);

  always_ff @(posedge clk or posedge resetM) begin
    if (resetM) begin
      div  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= wrap;
      div  <= wrap ? '0 : div + DIV_W'(1);
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA pixel timing generator: pixel enable, H/V counters, syncs and active flags.
// Optional frame_start pulse when VGA_FRAME_PULSE_EN is defined.
module vga_sync_gen #(
  parameter int CLK_DIV = 4,
  parameter int H_BP    = vga_timing_pkg::DEF_H_BP,
  parameter int H_ACT   = vga_timing_pkg::DEF_H_ACT,
  parameter int H_FP    = vga_timing_pkg::DEF_H_FP,
  parameter int H_SYNC  = vga_timing_pkg::DEF_H_SYNC,
  parameter int V_BP    = vga_timing_pkg::DEF_V_BP,
  parameter int V_ACT   = vga_timing_pkg::DEF_V_ACT,
  parameter int V_FP    = vga_timing_pkg::DEF_V_FP,
  parameter int V_SYNC  = vga_timing_pkg::DEF_V_SYNC
) (
  input  logic           clk,
  input  logic           resetM,
  vga_sync_gen_if.master vga
);
  import vga_timing_pkg::*;

  localparam int L_H_TOTAL = H_BP + H_ACT + H_FP + H_SYNC;
  localparam int L_V_TOTAL = V_BP + V_ACT + V_FP + V_SYNC;

  if (L_H_TOTAL >= (1 << COORD_W) || L_V_TOTAL >= (1 << COORD_W) ||
      CLK_DIV < 1 || CLK_DIV > 16) begin : g_cfg_err
    $error("vga_sync_gen: timing totals must fit in COORD_W bits and CLK_DIV in 1..16");
  end

  localparam logic [COORD_W-1:0] H_LAST    = COORD_W'(L_H_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ON_LO   = COORD_W'(H_BP);
  localparam logic [COORD_W-1:0] H_ON_HI   = COORD_W'(H_BP + H_ACT);
  localparam logic [COORD_W-1:0] H_SYNC_LO = COORD_W'(H_BP + H_ACT + H_FP);
  localparam logic [COORD_W-1:0] V_LAST    = COORD_W'(L_V_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_ON_LO   = COORD_W'(V_BP);
  localparam logic [COORD_W-1:0] V_ON_HI   = COORD_W'(V_BP + V_ACT);
  localparam logic [COORD_W-1:0] V_SYNC_LO = COORD_W'(V_BP + V_ACT + V_FP);

  logic               pix_tick;
  logic [COORD_W-1:0] qh, qv, qh_nxt, qv_nxt;
  logic               h_wrap, v_wrap;
  logic               h_on, v_on, hsync, vsync;

  pix_clk_en #(.CLK_DIV(CLK_DIV)) u_pix_clk_en (
    .clk    (clk),
    .resetM (resetM),
    .tick   (pix_tick)
  );

  assign h_wrap = (qh == H_LAST);
  assign v_wrap = (qv == V_LAST);

  always_comb begin
    qh_nxt = qh + COORD_W'(1);
    qv_nxt = qv;
    if (h_wrap) begin
      qh_nxt = '0;
      qv_nxt = v_wrap ? '0 : qv + COORD_W'(1);
    end
  end

  // Flags decode the next count so they change on the same edge as Qh/Qv
  always_ff @(posedge clk or posedge resetM) begin
    if (resetM) begin
      qh    <= '0;
      qv    <= '0;
      h_on  <= 1'b0;
      v_on  <= 1'b0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else if (pix_tick) begin
      qh    <= qh_nxt;
      qv    <= qv_nxt;
      h_on  <= in_span(qh_nxt, H_ON_LO, H_ON_HI);
      v_on  <= in_span(qv_nxt, V_ON_LO, V_ON_HI);
      hsync <= !(qh_nxt >= H_SYNC_LO);
      vsync <= !(qv_nxt >= V_SYNC_LO);
    end
  end

  assign vga.pix_tick = pix_tick;
  assign vga.Qh       = qh;
  assign vga.Qv       = qv;
  assign vga.H_ON     = h_on;
  assign vga.V_ON     = v_on;
  assign vga.hsync    = hsync;
  assign vga.vsync    = vsync;

`ifdef VGA_FRAME_PULSE_EN
  logic frame_start;

  // Only the counter wrap raises it; reset release leaves it low
  always_ff @(posedge clk or posedge resetM) begin
    if (resetM) frame_start <= 1'b0;
    else        frame_start <= pix_tick && h_wrap && v_wrap;
  end

  assign vga.frame_start = frame_start;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: DUT a uses default timing at CLK_DIV=4,
// DUT b uses CLK_DIV=1 with an 11-line frame so a full frame fits the run.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic resetM = 1'b1;
  logic sel_b = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vga_sync_gen_if if_a ();
  vga_sync_gen_if if_b ();

  vga_sync_gen #(.CLK_DIV(4)) u_dut_a (
    .clk    (clk),
    .resetM (resetM),
    .vga    (if_a)
  );

  vga_sync_gen #(.CLK_DIV(1), .V_BP(3), .V_ACT(4), .V_FP(2), .V_SYNC(2)) u_dut_b (
    .clk    (clk),
    .resetM (resetM),
    .vga    (if_b)
  );

  logic [9:0] c_qh, c_qv;
  logic       c_hon, c_von, c_hs, c_vs, c_tick, c_fs;

  always_comb begin
    c_qh   = sel_b ? if_b.Qh       : if_a.Qh;
    c_qv   = sel_b ? if_b.Qv       : if_a.Qv;
    c_hon  = sel_b ? if_b.H_ON     : if_a.H_ON;
    c_von  = sel_b ? if_b.V_ON     : if_a.V_ON;
    c_hs   = sel_b ? if_b.hsync    : if_a.hsync;
    c_vs   = sel_b ? if_b.vsync    : if_a.vsync;
    c_tick = sel_b ? if_b.pix_tick : if_a.pix_tick;
`ifdef VGA_FRAME_PULSE_EN
    c_fs   = sel_b ? if_b.frame_start : if_a.frame_start;
`else
    c_fs   = 1'b0;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_qh"},    32'(c_qh), 0);
    chk({nm, "_qv"},    32'(c_qv), 0);
    chk({nm, "_hon"},   32'(c_hon), 0);
    chk({nm, "_von"},   32'(c_von), 0);
    chk({nm, "_hsync"}, 32'(c_hs), 1);
    chk({nm, "_vsync"}, 32'(c_vs), 1);
    chk({nm, "_tick"},  32'(c_tick), 0);
`ifdef VGA_FRAME_PULSE_EN
    chk({nm, "_fs"},    32'(c_fs), 0);
`endif
  endtask

  // Measures the line that starts at the next Qh wrap
  task automatic scan_line(input string nm, input int exp_period, input int max_clk);
    int clk_n = 0, start = 0, period = 0, pix = 0, hon = 0, hsl = 0, qv_chg = 0, wraps = 0;
    logic [9:0] pqh, pqv;
    @(negedge clk);
    pqh = c_qh;
    pqv = c_qv;
    while (wraps < 2 && clk_n < max_clk) begin
      @(negedge clk);
      clk_n++;
      if (pqh == 10'd799 && c_qh == 10'd0) begin
        wraps++;
        if (wraps == 1) begin
          start = clk_n;
          chk({nm, "_qv_before_wrap"}, 32'(pqv), 0);
          chk({nm, "_qv_after_wrap"},  32'(c_qv), 1);
        end else begin
          period = clk_n - start;
        end
      end else if (wraps == 1 && c_qv != pqv) begin
        qv_chg++;
      end
      if (wraps == 1 && c_qh != pqh) begin
        pix++;
        if (c_hon) hon++;
        if (!c_hs) hsl++;
        case (c_qh)
          10'd47:  chk({nm, "_hon_47"},    32'(c_hon), 0);
          10'd48:  chk({nm, "_hon_48"},    32'(c_hon), 1);
          10'd687: chk({nm, "_hon_687"},   32'(c_hon), 1);
          10'd688: chk({nm, "_hon_688"},   32'(c_hon), 0);
          10'd703: chk({nm, "_hsync_703"}, 32'(c_hs), 1);
          10'd704: chk({nm, "_hsync_704"}, 32'(c_hs), 0);
          10'd799: chk({nm, "_hsync_799"}, 32'(c_hs), 0);
          default: ;
        endcase
      end
      pqh = c_qh;
      pqv = c_qv;
    end
    chk({nm, "_line_done"},   32'(wraps), 2);
    chk({nm, "_line_period"}, 32'(period), 32'(exp_period));
    chk({nm, "_line_pixels"}, 32'(pix), 800);
    chk({nm, "_hon_count"},   32'(hon), 640);
    chk({nm, "_hsync_count"}, 32'(hsl), 96);
    chk({nm, "_qv_hold"},     32'(qv_chg), 0);
  endtask

  // DUT b frame: V_ON for Qv 3..6, vsync low for Qv 9..10, 11 lines
  task automatic scan_frame(input int max_clk);
    int clk_n = 0, start = 0, period = 0, pix = 0, von = 0, vsl = 0, fs_n = 0;
    int bad_edge = 0, wraps = 0;
    logic [9:0] pqh, pqv;
    @(negedge clk);
    pqh = c_qh;
    pqv = c_qv;
    while (wraps < 2 && clk_n < max_clk) begin
      @(negedge clk);
      clk_n++;
      if (pqh == 10'd799 && pqv == 10'd10 && c_qh == 10'd0 && c_qv == 10'd0) begin
        wraps++;
        if (wraps == 1) begin
          start = clk_n;
`ifdef VGA_FRAME_PULSE_EN
          chk("f_fs_at_wrap", 32'(c_fs), 1);
`endif
        end else begin
          period = clk_n - start;
        end
      end
      if (wraps == 1) begin
        if (c_qh != pqh) begin
          pix++;
          if (c_von) von++;
          if (!c_vs) vsl++;
        end
        if (c_fs) fs_n++;
        if (c_qv != pqv) begin
          if (!(pqh == 10'd799 && c_qh == 10'd0)) bad_edge++;
          case (c_qv)
            10'd2:  chk("f_von_qv2",   32'(c_von), 0);
            10'd3:  chk("f_von_qv3",   32'(c_von), 1);
            10'd6:  chk("f_von_qv6",   32'(c_von), 1);
            10'd7:  chk("f_von_qv7",   32'(c_von), 0);
            10'd8:  chk("f_vsync_qv8", 32'(c_vs), 1);
            10'd9:  chk("f_vsync_qv9", 32'(c_vs), 0);
            default: ;
          endcase
        end
      end
      pqh = c_qh;
      pqv = c_qv;
    end
    chk("f_frame_done",   32'(wraps), 2);
    chk("f_frame_period", 32'(period), 8800);
    chk("f_frame_pixels", 32'(pix), 8800);
    chk("f_von_count",    32'(von), 3200);
    chk("f_vsync_count",  32'(vsl), 1600);
    chk("f_qv_step_edge", 32'(bad_edge), 0);
`ifdef VGA_FRAME_PULSE_EN
    chk("f_fs_count", 32'(fs_n), 1);
`else
    chk("f_fs_count", 32'(fs_n), 0);
`endif
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_a = 0, ticks_b = 0, found = 0;
    int a_hs = 0, a_vs = 0, b_hs = 0, b_vs = 0, fs_n = 0;

    repeat (10) @(negedge clk);
    sel_b = 1'b0; #1;
    check_reset("rst_a");
    sel_b = 1'b1; #1;
    check_reset("rst_b");

    @(negedge clk);
    resetM = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (if_a.pix_tick && first_a == 0) first_a = k;
      if (if_b.pix_tick) ticks_b++;
      if (k == 4) chk("a_qh_at_first_tick", 32'(if_a.Qh), 0);
    end
    chk("a_first_tick_clk", 32'(first_a), 4);
    chk("b_tick_constant",  32'(ticks_b), 8);

    sel_b = 1'b1;
    scan_line("b", 800, 2000);
    sel_b = 1'b0;
    scan_line("a", 3200, 8000);

    sel_b = 1'b1;
    scan_frame(18000);

    for (int k = 0; k < 9000 && found == 0; k++) begin
      @(negedge clk);
      if (if_b.Qh == 10'd300 && if_b.Qv == 10'd5) found = 1;
    end
    chk("mid_pos_found", 32'(found), 1);
    chk("mid_b_hon",     32'(if_b.H_ON), 1);
    chk("mid_b_von",     32'(if_b.V_ON), 1);
    #1 resetM = 1'b1;
    #1 sel_b = 1'b0;
    #1 check_reset("mid_a");
    sel_b = 1'b1;
    #1 check_reset("mid_b");

    repeat (3) @(negedge clk);
    resetM = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (!if_a.hsync) a_hs++;
      if (!if_a.vsync) a_vs++;
      if (!if_b.hsync) b_hs++;
      if (!if_b.vsync) b_vs++;
`ifdef VGA_FRAME_PULSE_EN
      if (if_a.frame_start || if_b.frame_start) fs_n++;
`endif
      if (k == 10) begin
        chk("restart_a_qh", 32'(if_a.Qh), 2);
        chk("restart_a_qv", 32'(if_a.Qv), 0);
        chk("restart_b_qh", 32'(if_b.Qh), 9);
        chk("restart_b_qv", 32'(if_b.Qv), 0);
      end
    end
    chk("restart_a_hsync_low", 32'(a_hs), 0);
    chk("restart_a_vsync_low", 32'(a_vs), 0);
    chk("restart_b_hsync_low", 32'(b_hs), 0);
    chk("restart_b_vsync_low", 32'(b_vs), 0);
    chk("restart_fs_count",    32'(fs_n), 0);
    chk("restart_b_qh_100",    32'(if_b.Qh), 99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Pixel timing generator for the 640x480 @ 60 Hz VGA path.
- Derives a pixel-rate enable from the system clock.
- Runs horizontal and vertical counters and produces sync pulses, active-video flags and pixel coordinates.
- Directly upstream of the colour/border stage, which consumes H_ON, V_ON, Qh and Qv unchanged.

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz); legal range 1..16
- H_BP, 48, horizontal back porch in pixels (counted first)
- H_ACT, 640, horizontal active pixels
- H_FP, 16, horizontal front porch pixels
- H_SYNC, 96, hsync width in pixels
- V_BP, 33, vertical back porch in lines (counted first)
- V_ACT, 480, active lines
- V_FP, 10, vertical front porch lines
- V_SYNC, 2, vsync width in lines

Ports:
- clk  in  1  system clock
- resetM  in  1  asynchronous, active-high reset
- pix_tick  out  1  one-clk pulse every CLK_DIV clocks; marks a pixel advance
- Qh  out  10  horizontal count 0..H_TOTAL-1 (H_TOTAL = 800)
- Qv  out  10  vertical count 0..V_TOTAL-1 (V_TOTAL = 525)
- H_ON  out  1  high while Qh is in [H_BP, H_BP+H_ACT-1] = [48, 687]
- V_ON  out  1  high while Qv is in [V_BP, V_BP+V_ACT-1] = [33, 512]
- hsync  out  1  active low while Qh is in [H_BP+H_ACT+H_FP, H_TOTAL-1] = [704, 799]
- vsync  out  1  active low while Qv is in [V_BP+V_ACT+V_FP, V_TOTAL-1] = [523, 524]

Behaviour:
- Reset (async assert, sync-to-clk release): divider = 0, pix_tick = 0, Qh = 0, Qv = 0, H_ON = 0, V_ON = 0, hsync = 1, vsync = 1.
- Divider: counts 0..CLK_DIV-1 and wraps. pix_tick is registered and high for exactly one clk when the divider wraps. The first pix_tick occurs CLK_DIV clocks after reset release. With CLK_DIV = 1, pix_tick is constantly 1 after the first clk.
- Counters advance only on clocks where pix_tick = 1; between ticks all outputs hold.
- Qh increments by 1 per tick; 799 -> 0.
- Qv increments only on the tick where Qh wraps 799 -> 0; 524 -> 0 on that same tick, giving a full frame wrap (799, 524) -> (0, 0).
- H_ON, V_ON, hsync and vsync are registered and decoded from the next-count values. They change on the same clk edge as Qh/Qv, so they are always consistent with the presented Qh/Qv; zero skew, no extra latency.
- Decode boundaries are inclusive-exclusive as stated under Ports. Examples: Qh = 47 -> H_ON = 0; Qh = 48 -> H_ON = 1; Qh = 688 -> H_ON = 0; Qh = 703 -> hsync = 1; Qh = 704 -> hsync = 0.
- Arithmetic: unsigned, 10 bits. All localparam sums must be < 1024; elaboration fails otherwise.
- Reset mid-frame: all state returns to reset values immediately. The next frame restarts at (0, 0) with no partial-sync glitch after release.
- Line rate: 800 ticks per line, 420000 ticks per frame.

Optional Feature:
- Macro: VGA_FRAME_PULSE_EN.
- Defined: adds output frame_start (1 bit, reset 0). It is registered and high for one clk, on the same edge where (Qh, Qv) becomes (0, 0) through the counter wrap. It is not asserted at reset release. It is intended to clear the clock/date font latches between frames.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package vga_timing_pkg holds:
  - default H_/V_ timing constants
  - derived H_TOTAL, V_TOTAL, H_ACT_START, H_ACT_END, H_SYNC_START, V_ACT_START, V_ACT_END, V_SYNC_START
  - COORD_W = 10
- Shared with the colour and font stages so border positions track the timing.
- One sub-module, pix_clk_en (the CLK_DIV enable divider, parameter CLK_DIV, ports clk, resetM, tick), which is reusable by the font ROM reader.

Test Plan:
- Reset: hold resetM = 1 for 10 clk, release -> Qh = 0, Qv = 0, hsync = 1, vsync = 1, H_ON = 0; first pix_tick exactly 4 clk after release.
- Horizontal decode, one line with CLK_DIV = 4 -> H_ON rises at Qh = 48, falls at Qh = 688; hsync low for Qh 704..799 (96 ticks); line period 3200 clk.
- Line-to-line rollover: Qh 799 -> 0 with Qv 33 -> 34 on the same edge; Qv holds for the other 799 ticks.
- Full frame -> V_ON high for Qv 33..512 (480 lines); vsync low for Qv 523..524 (1600 ticks); wrap (799, 524) -> (0, 0); frame = 420000 ticks. With VGA_FRAME_PULSE_EN, exactly one frame_start per frame, at that wrap.
- Mid-frame reset: assert resetM at Qh = 300, Qv = 200 between clk edges -> outputs reach reset values before the next edge; after release, counting restarts from (0, 0).
- CLK_DIV = 1 build: pix_tick constantly 1 after the first clk; line period = 800 clk; decode boundaries unchanged.
